// File: rtl/temp_pkg.sv
// ============================================================================
//  temp_pkg
//  Shared XADC temperature constants, averager state type and helpers.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package temp_pkg;

    localparam int XADC_WIDTH = 12;

    // Station classification thresholds, shared with the station-detect logic.
    localparam int COLD_MAX = 1200;
    localparam int HOT_MIN  = 1900;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } avg_state_e;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_ring.sv
// ============================================================================
//  sample_ring
//  DEPTH x WIDTH circular sample buffer with synchronous clear; exposes the
//  entry that the next write will overwrite.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sample_ring #(
    parameter int WIDTH      = 12,
    parameter int LOG2_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_old_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      ring_q [DEPTH];
    logic [WIDTH-1:0]      ring_d [DEPTH];
    logic [LOG2_DEPTH-1:0] wp_q;
    logic [LOG2_DEPTH-1:0] wp_d;

    assign o_old_data = ring_q[wp_q];

    always_comb begin
        ring_d = ring_q;
        wp_d   = wp_q;
        if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_d[i] = '0;
            end
            wp_d = '0;
        end else if (i_wr_en) begin
            ring_d[wp_q] = i_wr_data;
            // Pointer width equals log2 of depth, so wrap is implicit.
            wp_d         = wp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wp_q <= '0;
        end else begin
            ring_q <= ring_d;
            wp_q   <= wp_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/temp_sample_averager.sv
// ============================================================================
//  temp_sample_averager
//  Sliding-window moving average of XADC temperature samples with a level
//  ready flag. Optional outlier rejection: TEMP_AVG_OUTLIER_REJECT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module temp_sample_averager
    import temp_pkg::*;
#(
    parameter int WIDTH        = XADC_WIDTH,
    parameter int LOG2_DEPTH   = 3,
    parameter int REJECT_DELTA = 400
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      sampleIn,
    input  logic                  sampleValid,
    input  logic                  flush,
    output logic [WIDTH-1:0]      digitalTemp,
    output logic                  ready,
    output logic [LOG2_DEPTH:0]   sampleCount
`ifdef TEMP_AVG_OUTLIER_REJECT_EN
    ,
    output logic                  rejectPulse
`endif
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = WIDTH + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(DEPTH - 1);

`ifdef TEMP_AVG_OUTLIER_REJECT_EN
    localparam bit REJECT_EN = 1'b1;
`else
    localparam bit REJECT_EN = 1'b0;
`endif

    avg_state_e        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  avg_q, avg_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  w_old_sample;
    logic              w_reject;
    logic              w_accept;

    sample_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk        (CLK),
        .rst        (RST),
        .i_clear    (flush),
        .i_wr_en    (w_accept),
        .i_wr_data  (sampleIn),
        .o_old_data (w_old_sample)
    );

    // Outliers are judged against the published average, only once full.
    assign w_reject = REJECT_EN && (state_q == FULL) && sampleValid && !flush &&
                      (abs_diff(32'(sampleIn), 32'(avg_q)) > 32'(REJECT_DELTA));
    assign w_accept = sampleValid && !flush && !w_reject;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        avg_d   = WIDTH'(sum_q >> LOG2_DEPTH);
        ready_d = (state_q == FULL);
        if (flush) begin
            state_d = FILL;
            sum_d   = '0;
            count_d = '0;
            avg_d   = '0;
            ready_d = 1'b0;
        end else if (w_accept) begin
            // During FILL the slot being replaced still holds zero.
            sum_d = sum_q + SUM_W'(sampleIn) - SUM_W'(w_old_sample);
            if (state_q == FILL) begin
                count_d = count_q + 1'b1;
                if (count_q == LAST_FILL) begin
                    state_d = FULL;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FILL;
            sum_q   <= '0;
            count_q <= '0;
            avg_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            avg_q   <= avg_d;
            ready_q <= ready_d;
        end
    end

`ifdef TEMP_AVG_OUTLIER_REJECT_EN
    logic reject_q;
    logic reject_d;

    assign reject_d = w_reject;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end

    assign rejectPulse = reject_q;
`endif

    assign digitalTemp = avg_q;
    assign ready       = ready_q;
    assign sampleCount = count_q;

endmodule

`default_nettype wire
